// File: rtl/fetch_redirect_if.sv
// Fetch-stage redirect bundle: pipeline hazard/redirect requests in, PC steering and trap status out.
// The controller takes the slave view; the pipeline (or a bench) takes the master view.
interface fetch_redirect_if;
    logic       load_use_hazard;
    logic       branch_taken;
    logic       id_is_j;
    logic       id_is_jr;
    logic       exc_req;
    logic       irq;
    logic       kernel_mode;
    logic       PC_IF_ID_Write;
    logic [2:0] select_PC_next;
    logic [1:0] status;
    logic       flush_ID_EX;
    logic       irq_ack;
    logic       stall_timeout;

    modport master (
        output load_use_hazard, branch_taken, id_is_j, id_is_jr, exc_req, irq, kernel_mode,
        input  PC_IF_ID_Write, select_PC_next, status, flush_ID_EX, irq_ack, stall_timeout
    );

    modport slave (
        input  load_use_hazard, branch_taken, id_is_j, id_is_jr, exc_req, irq, kernel_mode,
        output PC_IF_ID_Write, select_PC_next, status, flush_ID_EX, irq_ack, stall_timeout
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect arbiter: picks one redirect source per cycle, latches deferred traps,
// blocks interrupts for a lockout window after each trap and watches for runaway stalls.
module fetch_redirect_ctrl #(
    parameter int LOCKOUT   = 4,
    parameter int MAX_STALL = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_redirect_if.slave    bus
);
    localparam int LW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
    localparam int SW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT);
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

    typedef enum logic [1:0] {RUN, TRAP, LOCK} state_t;
    typedef enum logic [2:0] {
        SRC_NONE, SRC_BRANCH, SRC_STALL, SRC_JR, SRC_J, SRC_EXC, SRC_IRQ
    } src_t;

    state_t        state, state_nx;
    src_t          src;
    logic [LW-1:0] lock_cnt, lock_cnt_nx;
    logic [SW-1:0] stall_cnt;
    logic          irq_s1, irq_s2, irq_d;
    logic          irq_pend, exc_pend;
    logic          stall_timeout_q;
    logic          trap_issue;
    logic          stalling;

    // Source arbitration; exactly one source acts per cycle.
    // NOTE: every combinational output gets a default before any branch, so no path infers a latch.
    always_comb begin
        src = SRC_NONE;
        if (bus.branch_taken)
            src = SRC_BRANCH;
        else if (bus.load_use_hazard)
            src = SRC_STALL;
        else if (bus.id_is_jr)
            src = SRC_JR;
        else if (bus.id_is_j)
            src = SRC_J;
        else if (bus.exc_req || exc_pend)
            src = SRC_EXC;
        else if (irq_pend && !bus.kernel_mode && state != LOCK)
            src = SRC_IRQ;
    end

    always_comb begin
        bus.PC_IF_ID_Write = 1'b1;
        bus.select_PC_next = 3'b000;
        bus.status         = 2'b00;
        bus.flush_ID_EX    = 1'b0;
        bus.irq_ack        = 1'b0;
        case (src)
            SRC_BRANCH: bus.select_PC_next = 3'b100;
            SRC_STALL: begin
                bus.PC_IF_ID_Write = 1'b0;
                bus.flush_ID_EX    = 1'b1;
            end
            SRC_JR:     bus.select_PC_next = 3'b001;
            SRC_J:      bus.select_PC_next = 3'b010;
            SRC_EXC: begin
                bus.status      = 2'b01;
                bus.flush_ID_EX = 1'b1;
            end
            SRC_IRQ: begin
                bus.status      = 2'b10;
                bus.flush_ID_EX = 1'b1;
                bus.irq_ack     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.stall_timeout = stall_timeout_q;
    assign trap_issue        = (src == SRC_EXC) || (src == SRC_IRQ);
    assign stalling          = (src == SRC_STALL);

    // Lockout FSM: any trap (re)arms the window; only interrupts honour it.
    always_comb begin
        state_nx    = state;
        lock_cnt_nx = lock_cnt;
        case (state)
            RUN: if (trap_issue) state_nx = TRAP;
            TRAP: begin
                if (LOCKOUT == 0) begin
                    state_nx = trap_issue ? TRAP : RUN;
                end else begin
                    state_nx    = LOCK;
                    lock_cnt_nx = LOCK_LOAD;
                end
            end
            LOCK: begin
                if (trap_issue) begin
                    lock_cnt_nx = LOCK_LOAD;
                end else begin
                    lock_cnt_nx = lock_cnt - LW'(1);
                    if (lock_cnt_nx == '0) state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            lock_cnt        <= '0;
            irq_s1          <= 1'b0;
            irq_s2          <= 1'b0;
            irq_d           <= 1'b0;
            irq_pend        <= 1'b0;
            exc_pend        <= 1'b0;
            stall_cnt       <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state    <= state_nx;
            lock_cnt <= lock_cnt_nx;
            irq_s1   <= bus.irq;
            irq_s2   <= irq_s1;
            irq_d    <= irq_s2;

            // A new synchronised edge wins over the clear, so it is never lost.
            irq_pend <= (irq_pend && src != SRC_IRQ) || (irq_s2 && !irq_d);

            // Deferred exceptions: outranked requests and illegal j+jr both land here.
            if (src == SRC_EXC)
                exc_pend <= 1'b0;
            else if (bus.exc_req || (src == SRC_JR && bus.id_is_j))
                exc_pend <= 1'b1;

            if (stalling) begin
                if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + SW'(1);
                if (stall_cnt >= STALL_MAX - SW'(1)) stall_timeout_q <= 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Randomised bench for fetch_redirect_ctrl against a cycle-indexed reference model:
// irq history array, trap windows as cycle ranges, stall run length as a plain counter.
module tb_fetch_redirect_ctrl;
    localparam int LOCKOUT   = 4;
    localparam int MAX_STALL = 15;

    typedef enum {S_NONE, S_BR, S_STALL, S_JR, S_J, S_EXC, S_IRQ} src_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_redirect_if bus();

    fetch_redirect_ctrl #(.LOCKOUT(LOCKOUT), .MAX_STALL(MAX_STALL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state
    bit irq_hist [0:8191];
    int reset_base;
    bit exc_pend_m, irq_pend_m, timeout_m;
    int run_len;
    int nonrun_end;   // last cycle the controller is out of RUN
    int lock_start;   // first cycle interrupts are blocked

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    function automatic bit hist(input int i);
        return (i < reset_base) ? 1'b0 : irq_hist[i];
    endfunction

    function automatic bit locked(input int c);
        return (c >= lock_start) && (c <= nonrun_end);
    endfunction

    function automatic src_t pick();
        if (bus.branch_taken)                       return S_BR;
        if (bus.load_use_hazard)                    return S_STALL;
        if (bus.id_is_jr)                           return S_JR;
        if (bus.id_is_j)                            return S_J;
        if (bus.exc_req || exc_pend_m)              return S_EXC;
        if (irq_pend_m && !bus.kernel_mode && !locked(cyc)) return S_IRQ;
        return S_NONE;
    endfunction

    // {write, select[2:0], status[1:0], flush, ack, timeout}
    function automatic logic [8:0] model_out(input src_t s);
        logic       w;
        logic [2:0] sel;
        logic [1:0] st;
        w   = (s != S_STALL);
        sel = (s == S_BR) ? 3'b100 : (s == S_JR) ? 3'b001 : (s == S_J) ? 3'b010 : 3'b000;
        st  = (s == S_EXC) ? 2'b01 : (s == S_IRQ) ? 2'b10 : 2'b00;
        return {w, sel, st, (s == S_STALL || s == S_EXC || s == S_IRQ), (s == S_IRQ), timeout_m};
    endfunction

    function automatic logic [8:0] dut_out();
        return {bus.PC_IF_ID_Write, bus.select_PC_next, bus.status,
                bus.flush_ID_EX, bus.irq_ack, bus.stall_timeout};
    endfunction

    task automatic model_clear();
        exc_pend_m = 0; irq_pend_m = 0; timeout_m = 0;
        run_len = 0; nonrun_end = -1; lock_start = 0;
    endtask

    task automatic model_update(input src_t s);
        bit edge_seen;
        edge_seen = hist(cyc - 2) && !hist(cyc - 3);
        if (s == S_EXC)
            exc_pend_m = 0;
        else if (bus.exc_req || (s == S_JR && bus.id_is_j))
            exc_pend_m = 1;
        irq_pend_m = (irq_pend_m && s != S_IRQ) || edge_seen;
        if (s == S_EXC || s == S_IRQ) begin
            if (cyc <= nonrun_end) begin
                lock_start = cyc + 1;
                nonrun_end = cyc + LOCKOUT;
            end else begin
                lock_start = cyc + 2;
                nonrun_end = cyc + LOCKOUT + 1;
            end
        end
        if (s == S_STALL) begin
            run_len++;
            if (run_len == MAX_STALL) timeout_m = 1;
        end else begin
            run_len = 0;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step(input string tag);
        src_t       s;
        logic [8:0] g;
        irq_hist[cyc] = bus.irq;
        #1;
        s = pick();
        g = dut_out();
        check(tag, g, model_out(s));
        check("invariant", 9'(((g[7:5] != 0) && (g[4:3] != 0)) || (!g[8] && (g[7:3] != 0))), 9'd0);
        @(posedge clk);
        model_update(s);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        bus.load_use_hazard = 0; bus.branch_taken = 0;
        bus.id_is_j = 0; bus.id_is_jr = 0; bus.exc_req = 0;
    endtask

    task automatic do_reset();
        clear_reqs();
        bus.irq = 0; bus.kernel_mode = 0;
        rst_n = 0;
        model_clear();
        repeat (2) begin @(posedge clk); cyc++; end
        @(negedge clk);
        #1;
        check("reset", dut_out(), model_out(S_NONE));
        rst_n = 1;
        reset_base = cyc;
    endtask

    initial begin
        int acks;
        reset_base = 0;
        clear_reqs();
        bus.irq = 0; bus.kernel_mode = 0;
        @(negedge clk);

        // Idle after reset
        do_reset();
        repeat (10) step("idle");

        // Branch overrides load-use
        bus.load_use_hazard = 1; bus.branch_taken = 1;
        #1;
        check("br_over_stall_sel", 9'(bus.select_PC_next), 9'b100);
        check("br_over_stall_write", 9'(bus.PC_IF_ID_Write), 9'd1);
        check("br_over_stall_flush", 9'(bus.flush_ID_EX), 9'd0);
        step("br_over_stall");
        clear_reqs();
        step("idle");

        // Exception deferred behind a jump
        bus.exc_req = 1; bus.id_is_j = 1;
        #1;
        check("exc_behind_j_sel", 9'(bus.select_PC_next), 9'b010);
        step("exc_behind_j");
        clear_reqs();
        #1;
        check("exc_deferred_status", 9'(bus.status), 9'b01);
        check("exc_deferred_flush", 9'(bus.flush_ID_EX), 9'd1);
        step("exc_deferred");
        repeat (2) step("trap_lock");

        // Interrupt masked by kernel mode, taken when it drops
        acks = 0;
        bus.kernel_mode = 1; bus.irq = 1;
        repeat (6) begin
            #1;
            acks += int'(bus.irq_ack);
            step("irq_masked");
        end
        check("irq_masked_acks", 9'(acks), 9'd0);
        bus.kernel_mode = 0;
        #1;
        check("irq_unmask_ack", 9'(bus.irq_ack), 9'd1);
        check("irq_unmask_status", 9'(bus.status), 9'b10);
        step("irq_unmask");
        bus.irq = 0;
        repeat (8) step("idle");

        // Second interrupt during lockout waits for the window to close
        bus.irq = 1; step("irq_pulse");
        bus.irq = 0; step("irq_pulse");
        bus.irq = 1;
        acks = 0;
        repeat (12) begin
            #1;
            acks += int'(bus.irq_ack);
            step("irq_lockout");
        end
        check("irq_lockout_acks", 9'(acks), 9'd2);
        bus.irq = 0;
        repeat (4) step("idle");

        // Stall watchdog
        bus.load_use_hazard = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("stall_timeout_edge", 9'(bus.stall_timeout), 9'(i >= MAX_STALL));
            check("stall_write", 9'(bus.PC_IF_ID_Write), 9'd0);
            step("stall_run");
        end
        bus.load_use_hazard = 0;
        #1;
        check("stall_timeout_sticky", 9'(bus.stall_timeout), 9'd1);
        step("stall_release");

        // Randomised traffic with a mid-run reset
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            bus.branch_taken    = ($urandom % 10) == 0;
            bus.load_use_hazard = ($urandom % 7) == 0;
            bus.id_is_j         = ($urandom % 8) == 0;
            bus.id_is_jr        = ($urandom % 9) == 0;
            bus.exc_req         = ($urandom % 12) == 0;
            if (($urandom % 8) == 0) bus.irq = ~bus.irq;
            if (($urandom % 10) == 0) bus.kernel_mode = ~bus.kernel_mode;
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
